// File: rtl/cpu_defs.sv
// Shared CPU constants used by the fetch path and its surroundings.
package cpu_defs;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] NOP = 32'hE1A00000;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head reads as zero when empty.
module fetch_fifo
  import cpu_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [count_w(DEPTH)-1:0]  count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Discard everything buffered; the write side keeps its position.
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch front end: issues imem reads from the PC under a credit check and queues tagged words for decode.
module instruction_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = cpu_defs::ADDR_W,
  parameter int INSTR_W = cpu_defs::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  output logic               incrEnable,
  output logic               imemReq,
  output logic [ADDR_W-1:0]  imemAddr,
  input  logic [INSTR_W-1:0] imemData,
  input  logic               redirect,
  output logic               instrValid,
  input  logic               instrReady,
  output logic [INSTR_W-1:0] instrData,
  output logic [ADDR_W-1:0]  instrPc
);

  localparam int CW = cpu_defs::count_w(DEPTH);
  localparam int W  = ADDR_W + INSTR_W;

  logic [W-1:0]      fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CW:0]       level;

  assign instrValid = ~reset & ~fifo_empty;
  assign pop        = instrValid & instrReady & ~redirect;
  assign push       = inflight & ~redirect;

  // The outstanding read already owns a slot, so it counts against the credit.
  assign level = (CW+1)'(fifo_count) + (CW+1)'(inflight);
  assign issue = ~reset & ~redirect &
                 (pop | (~fifo_full & (level < (CW+1)'(DEPTH))));

  assign imemReq    = issue;
  assign incrEnable = issue;
  assign imemAddr   = pc;

  assign instrData = reset ? '0 : fifo_head[INSTR_W-1:0];
  assign instrPc   = reset ? '0 : fifo_head[W-1:INSTR_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= pc;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({inflight_pc, imemData}),
    .pop   (pop),
    .flush (redirect),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
